// File: rtl/ftdi_tx_arbiter.sv
// Round-robin arbiter that merges NCH requester streams into the single ftdi_245fifo send port.
// Define FTDI_TX_ARB_HEADER_EN to put a {4'hA, channel, seq} header word in front of every burst.
module ftdi_tx_arbiter #(
  parameter int NCH       = 4,
  parameter int DSIZE     = 2,
  parameter int MAX_BURST = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         itvalid,
  output logic [NCH-1:0]         itready,
  input  logic [NCH*DSIZE*8-1:0] itdata,
  input  logic [NCH-1:0]         itlast,
  output logic                   otvalid,
  input  logic                   otready,
  output logic [DSIZE*8-1:0]     otdata,
  output logic [1:0]             dbg_state
);

  localparam int DW = DSIZE * 8;
  localparam int GW = $clog2(NCH);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  // Handshake: a word moves when valid and ready are both high at a rising clk edge;
  // a source holds its word stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [GW-1:0]  r_grant;
  logic [GW-1:0]  w_grant_nxt;
  logic [GW-1:0]  r_last_grant;
  logic [GW-1:0]  w_last_grant_nxt;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_nxt;

  logic           w_any;
  logic [GW-1:0]  w_pick;
  logic [GW:0]    w_idx;
  logic           w_burst_end;
  logic [DW-1:0]  w_chan [NCH];

  assign dbg_state = r_state;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_chan[k] = itdata[k*DW +: DW];
    end
  end

  // Walk from last_grant+NCH down to last_grant+1 so the nearest requester wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int i = NCH; i >= 1; i--) begin
      w_idx = {1'b0, r_last_grant} + (GW+1)'(i);
      if (w_idx >= (GW+1)'(NCH)) begin
        w_idx = w_idx - (GW+1)'(NCH);
      end
      if (itvalid[w_idx[GW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[GW-1:0];
      end
    end
  end

  assign w_burst_end = (r_state == S_DATA) && itvalid[r_grant] && otready &&
                       (itlast[r_grant] || (r_count == LAST_CNT));

`ifdef FTDI_TX_ARB_HEADER_EN
  logic [7:0]    r_seq [NCH];
  logic [3:0]    w_gid;
  logic [DW-1:0] w_hdr;

  assign w_gid = 4'(r_grant);
  assign w_hdr = DW'({4'hA, w_gid, r_seq[r_grant]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        r_seq[k] <= 8'd0;
      end
    end else if (w_burst_end) begin
      r_seq[r_grant] <= r_seq[r_grant] + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NCH - 1);
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_count      <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_count_nxt      = r_count;
    otvalid          = 1'b0;
    otdata           = '0;
    itready          = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt      = w_pick;
          w_last_grant_nxt = w_pick;
          w_count_nxt      = '0;
`ifdef FTDI_TX_ARB_HEADER_EN
          w_state_nxt      = S_HDR;
`else
          w_state_nxt      = S_DATA;
`endif
        end
      end
`ifdef FTDI_TX_ARB_HEADER_EN
      S_HDR: begin
        otvalid = 1'b1;
        otdata  = w_hdr;
        if (otready) begin
          w_state_nxt = S_DATA;
        end
      end
`endif
      S_DATA: begin
        // Pure pass-through: a granted channel that goes idle simply stalls the output.
        otvalid          = itvalid[r_grant];
        otdata           = w_chan[r_grant];
        itready[r_grant] = otready;
        if (itvalid[r_grant] && otready) begin
          w_count_nxt = r_count + CW'(1);
        end
        if (w_burst_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/ftdi_tx_arbiter.md
# ftdi_tx_arbiter

Round-robin arbiter sharing the single user send stream of `ftdi_245fifo` (its `itvalid`/`itready`/`itdata` port) among NCH independent requester streams in the same clock domain. Each grant is a burst of up to MAX_BURST words, ended early by the requester's `itlast`. Optionally, each burst is preceded by a header word that identifies the channel, so the host can demultiplex the USB byte stream.

## Interface
- NCH, 4, number of requester channels; 2..16.
- DSIZE, 2, word width in bytes; must equal the `INPUT_DSIZE` of the downstream `ftdi_245fifo`; ≥2 when the header is compiled in.
- MAX_BURST, 256, maximum data words per grant; 1..65536.

- clk  in  1  user clock; the `iclk` of `ftdi_245fifo`.
- rst_n  in  1  asynchronous, active-low reset.
- itvalid  in  NCH  per-channel word valid.
- itready  out  NCH  per-channel word accepted.
- itdata  in  NCH*DSIZE*8  channel k occupies bits [k*DSIZE*8 +: DSIZE*8].
- itlast  in  NCH  marks channel k's current word as the last of its burst.
- otvalid  out  1  to `ftdi_245fifo.itvalid`.
- otready  in  1  from `ftdi_245fifo.itready`.
- otdata  out  DSIZE*8  to `ftdi_245fifo.itdata`.

## Operation
- Registered state: `state` ∈ {IDLE, HDR, DATA}, `grant` (clog2(NCH) bits), `last_grant`, `count` (burst word counter), and `seq[NCH]` (8-bit per-channel burst sequence numbers).
- Reset values: state=IDLE, last_grant=NCH-1 (channel 0 has first priority), grant=0, count=0, all seq=0. During reset, otvalid=0 and itready=0.
- IDLE: otvalid=0; itready=0. If any itvalid bit is set, the arbiter grants the first set channel searching from last_grant+1 upward, with wrap-around. It then loads grant and last_grant with that channel, clears count, and moves to HDR (header compiled in) or DATA (header compiled out). If no itvalid bit is set, it stays in IDLE.
- HDR: otvalid=1 and otdata=header; all itready=0. On otready, the state moves to DATA.
- DATA: a combinational pass-through of the granted channel.
  - otvalid=itvalid[grant]; otdata=itdata[grant]; itready[grant]=otready. All other itready bits are 0.
  - On each handshake (otvalid&otready), count increments.
  - If the word carries itlast[grant], or count==MAX_BURST-1, then: seq[grant] increments (wrapping at 255), and the state moves to IDLE.
- A channel that drops itvalid mid-burst keeps its grant. DATA holds with otvalid=0 until that channel resumes; there is no timeout.
- itlast on a non-granted channel is ignored.
- Arbitration is fair: a channel that is continuously requesting waits at most NCH-1 bursts.

## Timing
- Arbitration costs one IDLE cycle per burst: itvalid sampled high in IDLE gives otvalid=1 on the next cycle.
- With the header compiled in, each burst adds one more cycle (HDR) before data, assuming otready=1.
- DATA path latency from itvalid/itdata to otvalid/otdata is 0 cycles (combinational). Likewise, otready to itready is combinational.
- Downstream stall: otready=0 holds otvalid and otdata stable in both HDR and DATA. This relies on requesters holding their data while itready=0.
- Worst-case throughput with the header and otready=1 is MAX_BURST/(MAX_BURST+2) words per cycle.
- Simultaneous events: the burst end and a new request in the same cycle cause no fast path. IDLE is always entered and arbitrates on the next cycle using the updated last_grant.
- When rst_n is asserted mid-burst, all registers return to their reset values immediately. Any partially sent burst is abandoned; the host detects this by a missing seq value.

## Configuration
- `FTDI_TX_ARB_HEADER_EN` defined: HDR state exists. Header word = {4'hA, grant[3:0], seq[grant][7:0]} in the low 16 bits; any bits above bit 15 are zero.
- `FTDI_TX_ARB_HEADER_EN` undefined: HDR is removed and IDLE goes directly to DATA. seq registers are not implemented. The output is the raw concatenation of bursts.

## Test plan
- Reset, then only channel 2 sends 3 words 0x1111, 0x2222, 0x3333 with itlast on the third word; otready=1; header enabled → otdata sequence 0xA200, 0x1111, 0x2222, 0x3333; otvalid falls for one IDLE cycle afterwards.
- All 4 channels continuously valid, MAX_BURST=4, no itlast → grant order 0,1,2,3,0…; each burst has exactly 4 data words; headers 0xA000, 0xA100, 0xA200, 0xA300, then 0xA001 on the second round.
- otready toggled with a random 50% duty during bursts → no word lost or duplicated; otdata stable whenever otvalid=1 and otready=0; each channel's output order matches its input order.
- Granted channel 1 drops itvalid for 10 cycles mid-burst while channel 3 is requesting → otvalid=0 for those 10 cycles; channel 3 gets no itready until channel 1 asserts itlast.
- rst_n pulsed low in DATA after 2 of 5 words → itready/otvalid go to 0 asynchronously; after release, channel 0 wins first and its header seq=0x00.
- Header compiled out, channel 0 sends 0xBEEF with itlast → output is 0xBEEF alone, appearing 1 cycle after itvalid rises.
